// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// FSM state encoding and requester port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter.
// master = requester (core or loader), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                req;
  logic                lock;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                gnt;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, lock, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker for the memory arbiter.
// On a tie the port that did not win last time is chosen.
module mem_arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic idx,
  output logic valid
);

  // choose winner index; idx is don't-care when valid=0
  always_comb begin
    valid = req0 | req1;
    idx   = 1'b0;
    unique case (1'b1)
      (req0 & req1):  idx = ~rr_last;
      (req1 & ~req0): idx = 1'b1;
      default:        idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with lock for the shared memory port.
// Optional perf counters when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   port0,
  mem_port_arbiter_if.slave   port1,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_wait0,
  output logic [31:0]         perf_wait1,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  arb_state_e    state;
  logic          rr_last;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    rvalid_q;

  logic eff0;
  logic eff1;
  logic pick_idx;
  logic pick_valid;
  logic gnt0;
  logic gnt1;
  logic lock_sel;
  logic forced;
  logic rel0;
  logic rel1;

  // a locked owner hides the other port from the picker
  assign eff0 = port0.req & ~rst & (state != LOCK1);
  assign eff1 = port1.req & ~rst & (state != LOCK0);

  mem_arb_rr_pick u_pick (
    .req0    (eff0),
    .req1    (eff1),
    .rr_last (rr_last),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign gnt0 = pick_valid & (pick_idx == PORT_CORE);
  assign gnt1 = pick_valid & (pick_idx == PORT_DBG);
  assign port0.gnt = gnt0;
  assign port1.gnt = gnt1;

  assign lock_sel = pick_idx ? port1.lock : port0.lock;

  // lock_cnt is 1 after the first locked grant, so the
  // owner's LOCK_MAX-th cycle is the one that sees CNT_LAST
  assign forced = lock_cnt >= CNT_LAST;

  // in LOCKN a pending reqN is always granted, so only
  // lockN decides a voluntary release
  assign rel0 = (gnt0 & ~port0.lock)
              | (~port0.req & ~port0.lock) | forced;
  assign rel1 = (gnt1 & ~port1.lock)
              | (~port1.req & ~port1.lock) | forced;

  // steer the granted port onto the memory bus
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (1'b1)
      gnt0: begin
        mem_we    = port0.we;
        mem_addr  = port0.addr;
        mem_wdata = port0.wdata;
        mem_wstrb = port0.wstrb;
      end
      gnt1: begin
        mem_we    = port1.we;
        mem_addr  = port1.addr;
        mem_wdata = port1.wdata;
        mem_wstrb = port1.wstrb;
      end
      default: ;
    endcase
  end

  // arbitration FSM, lock counter and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q[0] <= gnt0 & ~port0.we;
      rvalid_q[1] <= gnt1 & ~port1.we;
      if (pick_valid)
        rr_last <= pick_idx;
      unique case (state)
        ARB: begin
          if (pick_valid && lock_sel) begin
            state    <= pick_idx ? LOCK1 : LOCK0;
            lock_cnt <= CW'(1);
          end
        end
        LOCK0: begin
          if (lock_cnt != CNT_MAX)
            lock_cnt <= lock_cnt + CW'(1);
          if (rel0) begin
            state    <= ARB;
            lock_cnt <= '0;
          end
        end
        LOCK1: begin
          if (lock_cnt != CNT_MAX)
            lock_cnt <= lock_cnt + CW'(1);
          if (rel1) begin
            state    <= ARB;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // reset masks rvalid at once so a read granted just
  // before reset never returns data
  assign port0.rvalid = rvalid_q[0] & ~rst;
  assign port1.rvalid = rvalid_q[1] & ~rst;
  assign port0.rdata  = port0.rvalid ? mem_rdata : '0;
  assign port1.rdata  = port1.rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  // wait and conflict cycle counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_wait0    <= '0;
      perf_wait1    <= '0;
      perf_conflict <= '0;
    end else begin
      if (port0.req && !gnt0)
        perf_wait0 <= perf_wait0 + 32'd1;
      if (port1.req && !gnt1)
        perf_wait1 <= perf_wait1 + 32'd1;
      if (port0.req && port1.req)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LOCK_MAX=4).
// Per-cycle vector table plus short hand sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_wait0;
  logic [31:0] perf_wait1;
  logic [31:0] perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1 ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .port0     (p0),
    .port1     (p1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_wait0    (perf_wait0),
    .perf_wait1    (perf_wait1),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hDEADBEEF ^ (a - 32'h10);
  endfunction

  // sync-read memory model
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= f(mem_addr);
  end

  typedef struct {
    logic        rst;
    logic        r0;
    logic        l0;
    logic [31:0] a0;
    logic        r1;
    logic        l1;
    logic [31:0] a1;
    logic        g0;
    logic        g1;
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        en;
    logic [31:0] ad;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic l0, input logic [31:0] a0,
    input logic r1, input logic l1, input logic [31:0] a1,
    input logic g0, input logic g1,
    input logic v0, input logic v1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic en, input logic [31:0] ad);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.l0 = l0; v.a0 = a0;
    v.r1 = r1; v.l1 = l1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.d0 = d0; v.d1 = d1; v.en = en; v.ad = ad;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(
    input logic rs,
    input logic r0, input logic l0, input logic w0,
    input logic [31:0] a0,
    input logic r1, input logic l1, input logic w1,
    input logic [31:0] a1);
    rst = rs;
    p0.req = r0; p0.lock = l0; p0.we = w0; p0.addr = a0;
    p1.req = r1; p1.lock = l1; p1.we = w1; p1.addr = a1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    p0.req = 0; p0.lock = 0; p0.we = 0; p0.addr = '0;
    p0.wdata = 32'hA0A0A0A0; p0.wstrb = 4'h3;
    p1.req = 0; p1.lock = 0; p1.we = 0; p1.addr = '0;
    p1.wdata = 32'hB1B1B1B1; p1.wstrb = 4'hC;

    // reset with both requesting
    vq.push_back(mk(1,1,0,0,1,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,0,1,0,0, 0,0,0,0,0,0,0,0));
    // single read by port 0
    vq.push_back(mk(0,1,0,'h10,0,0,0,
                    1,0,0,0,0,0,1,'h10));
    vq.push_back(mk(0,0,0,0,0,0,0,
                    0,0,1,0,f('h10),0,0,0));
    // contention from reset: 0,1,0,1
    vq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,'h20,1,0,'h30,
                    1,0,0,0,0,0,1,'h20));
    vq.push_back(mk(0,1,0,'h20,1,0,'h30,
                    0,1,1,0,f('h20),0,1,'h30));
    vq.push_back(mk(0,1,0,'h20,1,0,'h30,
                    1,0,0,1,0,f('h30),1,'h20));
    vq.push_back(mk(0,1,0,'h20,1,0,'h30,
                    0,1,1,0,f('h20),0,1,'h30));
    vq.push_back(mk(0,0,0,0,0,0,0,
                    0,0,0,1,0,f('h30),0,0));
    // port 1 locks for 3 accesses, port 0 stalls
    vq.push_back(mk(0,1,0,'h50,0,0,0,
                    1,0,0,0,0,0,1,'h50));
    vq.push_back(mk(0,1,0,'h50,1,1,'h40,
                    0,1,1,0,f('h50),0,1,'h40));
    vq.push_back(mk(0,1,0,'h50,1,1,'h40,
                    0,1,0,1,0,f('h40),1,'h40));
    vq.push_back(mk(0,1,0,'h50,1,0,'h40,
                    0,1,0,1,0,f('h40),1,'h40));
    // port 0 lock held: forced release after 4
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    1,0,0,1,0,f('h40),1,'h60));
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    1,0,1,0,f('h60),0,1,'h60));
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    1,0,1,0,f('h60),0,1,'h60));
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    1,0,1,0,f('h60),0,1,'h60));
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    0,1,1,0,f('h60),0,1,'h70));
    // read + lock granted, then reset mid-read
    vq.push_back(mk(0,1,1,'h60,1,0,'h70,
                    1,0,0,1,0,f('h70),1,'h60));
    vq.push_back(mk(1,1,1,'h60,1,0,'h70,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,0,'h70,
                    0,1,0,0,0,0,1,'h70));
    vq.push_back(mk(0,0,0,0,0,0,0,
                    0,0,0,1,0,f('h70),0,0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].r0, vq[i].l0, 1'b0,
            vq[i].a0, vq[i].r1, vq[i].l1, 1'b0,
            vq[i].a1);
      #3;
      chk("gnt0", i, 32'(p0.gnt), 32'(vq[i].g0));
      chk("gnt1", i, 32'(p1.gnt), 32'(vq[i].g1));
      chk("rvalid0", i, 32'(p0.rvalid), 32'(vq[i].v0));
      chk("rvalid1", i, 32'(p1.rvalid), 32'(vq[i].v1));
      chk("rdata0", i, p0.rdata, vq[i].d0);
      chk("rdata1", i, p1.rdata, vq[i].d1);
      chk("mem_en", i, 32'(mem_en), 32'(vq[i].en));
      chk("mem_we", i, 32'(mem_we), 32'd0);
      chk("mem_addr", i, mem_addr, vq[i].ad);
      next_cycle();
    end

    // write by port 1; lock0 without req0 is ignored
    drive(0, 0,1,0,'0, 1,0,1,'h80);
    #3;
    chk("w_gnt1", 0, 32'(p1.gnt), 32'd1);
    chk("w_we", 0, 32'(mem_we), 32'd1);
    chk("w_addr", 0, mem_addr, 32'h80);
    chk("w_wdata", 0, mem_wdata, 32'hB1B1B1B1);
    chk("w_wstrb", 0, 32'(mem_wstrb), 32'hC);
    next_cycle();
    drive(0, 1,0,0,'h90, 1,0,0,'h84);
    #3;
    chk("w_rvalid1", 1, 32'(p1.rvalid), 32'd0);
    chk("w_gnt0", 1, 32'(p0.gnt), 32'd1);
    chk("w_gnt1", 1, 32'(p1.gnt), 32'd0);
    next_cycle();

    // lock held with req0=0 keeps port 1 stalled
    drive(0, 1,1,0,'h90, 0,0,0,'0);
    #3;
    chk("h_gnt0", 0, 32'(p0.gnt), 32'd1);
    next_cycle();
    drive(0, 0,1,0,'h90, 1,0,0,'h88);
    #3;
    chk("h_gnt1", 1, 32'(p1.gnt), 32'd0);
    chk("h_en", 1, 32'(mem_en), 32'd0);
    next_cycle();
    drive(0, 0,0,0,'h90, 1,0,0,'h88);
    #3;
    chk("h_gnt1", 2, 32'(p1.gnt), 32'd0);
    next_cycle();
    #3;
    chk("h_gnt1", 3, 32'(p1.gnt), 32'd1);
    chk("h_addr", 3, mem_addr, 32'h88);
    next_cycle();

`ifdef MEM_ARB_PERF_EN
    drive(1, 0,0,0,'0, 0,0,0,'0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1,0,0,'h20, 1,0,0,'h30);
      next_cycle();
    end
    drive(0, 0,0,0,'0, 0,0,0,'0);
    #3;
    chk("perf_conflict", 0, perf_conflict, 32'd4);
    chk("perf_wait0", 0, perf_wait0, 32'd2);
    chk("perf_wait1", 0, perf_wait1, 32'd2);
    next_cycle();
`endif

    drive(0, 0,0,0,'0, 0,0,0,'0);
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
